// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill and flush sequencer.
// A miss fetches one line as a pipelined burst of 32-bit reads, assembles it
// and writes it to the cache fill port with a single-cycle strobe. A flush
// request drives cache_flush_o for CACHEDEPTH consecutive cycles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting; flush (requested or pending) wins over a miss
// S_FETCH | issuing line reads and collecting in-order responses
// S_FILL  | one-cycle cache write of the assembled line
// S_FLUSH | cache_flush_o asserted, flush_cnt_q counts 0..CACHEDEPTH-1
module icache_refill_ctrl #(
    parameter int LOG2CACHELINESIZE = 7,
    parameter int CACHELINESIZE     = 2**LOG2CACHELINESIZE,
    parameter int LOG2CACHEDEPTH    = 6,
    parameter int CACHEDEPTH        = 2**LOG2CACHEDEPTH,
    parameter int WORDS             = CACHELINESIZE/32
) (
    input  logic                     mem_clk,
    input  logic                     resetn,
    input  logic                     miss_req_i,
    input  logic [31:0]              miss_addr_i,
    input  logic                     flush_req_i,
    output logic                     busy_o,
    output logic                     fill_done_o,
    output logic                     flush_done_o,
    output logic [31:0]              mem_address_o,
    output logic                     mem_read_o,
    input  logic                     mem_waitrequest_i,
    input  logic [31:0]              mem_readdata_i,
    input  logic                     mem_readdatavalid_i,
    output logic [31:0]              fill_addr_o,
    output logic [CACHELINESIZE-1:0] fill_data_o,
    output logic                     fill_we_o,
    output logic                     cache_flush_o
);

    localparam int OFFW = LOG2CACHELINESIZE - 3;
    localparam int CNTW = $clog2(WORDS) + 1;
    localparam logic [CNTW-1:0]           WORDS_C   = CNTW'(WORDS);
    localparam logic [CNTW-1:0]           LAST_WORD = CNTW'(WORDS - 1);
    localparam logic [LOG2CACHEDEPTH-1:0] LAST_LINE = LOG2CACHEDEPTH'(CACHEDEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FILL,
        S_FLUSH
    } state_t;

    state_t                    state_q, state_d;
    logic [31:0]               line_addr_q, line_addr_d;
    logic [CNTW-1:0]           issue_cnt_q, issue_cnt_d;
    logic [CNTW-1:0]           recv_cnt_q, recv_cnt_d;
    logic [LOG2CACHEDEPTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                      flush_pending_q, flush_pending_d;
    logic [CACHELINESIZE-1:0]  line_q, line_d;
    logic [31:0]               fill_addr_q, fill_addr_d;
    logic [CACHELINESIZE-1:0]  fill_data_q, fill_data_d;

    // Byte offset within a line is dropped when forming the line address.
    logic unused_offset;
    assign unused_offset = ^miss_addr_i[OFFW-1:0];

    // State and datapath registers; reset clears everything to idle.
    always_ff @(posedge mem_clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            line_addr_q     <= '0;
            issue_cnt_q     <= '0;
            recv_cnt_q      <= '0;
            flush_cnt_q     <= '0;
            flush_pending_q <= 1'b0;
            line_q          <= '0;
            fill_addr_q     <= '0;
            fill_data_q     <= '0;
        end else begin
            state_q         <= state_d;
            line_addr_q     <= line_addr_d;
            issue_cnt_q     <= issue_cnt_d;
            recv_cnt_q      <= recv_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
            flush_pending_q <= flush_pending_d;
            line_q          <= line_d;
            fill_addr_q     <= fill_addr_d;
            fill_data_q     <= fill_data_d;
        end
    end

    // Next-state and Moore outputs. The fill registers are loaded on the
    // last beat so they are valid during S_FILL and hold until the next fill.
    always_comb begin
        state_d         = state_q;
        line_addr_d     = line_addr_q;
        issue_cnt_d     = issue_cnt_q;
        recv_cnt_d      = recv_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        flush_pending_d = flush_pending_q;
        line_d          = line_q;
        fill_addr_d     = fill_addr_q;
        fill_data_d     = fill_data_q;
        mem_read_o      = 1'b0;
        mem_address_o   = '0;
        fill_we_o       = 1'b0;
        fill_done_o     = 1'b0;
        cache_flush_o   = 1'b0;
        flush_done_o    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (flush_req_i || flush_pending_q) begin
                    flush_pending_d = 1'b0;
                    flush_cnt_d     = '0;
                    state_d         = S_FLUSH;
                end else if (miss_req_i) begin
                    line_addr_d = {miss_addr_i[31:OFFW], {OFFW{1'b0}}};
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (flush_req_i) begin
                    flush_pending_d = 1'b1;
                end
                mem_read_o    = (issue_cnt_q < WORDS_C);
                mem_address_o = line_addr_q + 32'({issue_cnt_q, 2'b00});
                if (mem_read_o && !mem_waitrequest_i) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (mem_readdatavalid_i && (recv_cnt_q < WORDS_C)) begin
                    line_d[32*recv_cnt_q[CNTW-2:0] +: 32] = mem_readdata_i;
                    recv_cnt_d = recv_cnt_q + 1'b1;
                    if (recv_cnt_q == LAST_WORD) begin
                        fill_addr_d = line_addr_q;
                        fill_data_d = line_d;
                        state_d     = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (flush_req_i) begin
                    flush_pending_d = 1'b1;
                end
                fill_we_o   = 1'b1;
                fill_done_o = 1'b1;
                state_d     = S_IDLE;
            end
            S_FLUSH: begin
                cache_flush_o = 1'b1;
                flush_cnt_d   = flush_cnt_q + 1'b1;
                if (flush_cnt_q == LAST_LINE) begin
                    flush_done_o = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign fill_addr_o = fill_addr_q;
    assign fill_data_o = fill_data_q;

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Line-refill and flush sequencer on mem_clk, directly upstream of the instruction cache fill port. On a miss request it issues a pipelined burst of 32-bit reads to the memory hierarchy, assembles them into one cache line, and writes the line to the cache with a one-cycle fill strobe. It also drives the cache flush input for exactly CACHEDEPTH consecutive cycles on request.

Parameters:
LOG2CACHELINESIZE, 7, log2 of line width in bits (128-bit line)
CACHELINESIZE, 2**LOG2CACHELINESIZE, line width in bits
LOG2CACHEDEPTH, 6, log2 of number of cache lines
CACHEDEPTH, 2**LOG2CACHEDEPTH, number of cache lines (flush length in cycles)
WORDS, CACHELINESIZE/32, 32-bit beats per line (4)

Ports:
mem_clk  in  1  clock
resetn  in  1  asynchronous active-low reset
miss_req  in  1  level; refill request, already in mem_clk domain
miss_addr  in  32  byte address of missing instruction
flush_req  in  1  single-cycle flush request pulse
busy  out  1  high whenever state != IDLE
fill_done  out  1  one-cycle pulse, coincident with fill_we
flush_done  out  1  one-cycle pulse on last flush cycle
mem_address  out  32  byte address of current read beat
mem_read  out  1  read request; held until accepted
mem_waitrequest  in  1  memory stall; request accepted when mem_read & !mem_waitrequest
mem_readdata  in  32  returned read word
mem_readdatavalid  in  1  mem_readdata valid this cycle; in-order responses
fill_addr  out  32  line address to cache fill port
fill_data  out  CACHELINESIZE  assembled line
fill_we  out  1  one-cycle cache line write strobe
cache_flush  out  1  to cache flush input; high exactly CACHEDEPTH cycles per flush

Behaviour:
- Reset: resetn asynchronous, active-low, clock mem_clk. All outputs 0, state IDLE, counters 0, flush_pending 0.
- States: IDLE, FETCH, FILL, FLUSH.
- IDLE: flush_req or flush_pending -> FLUSH (priority over miss). Else miss_req -> capture line_addr = {miss_addr[31:LOG2CACHELINESIZE-3], zeros}; clear issue_cnt and recv_cnt; -> FETCH.
- FETCH:
  - mem_read = (issue_cnt < WORDS).
  - mem_address = line_addr + 4*issue_cnt.
  - issue_cnt increments on each accepted request; address and mem_read are held stable while mem_waitrequest is high.
  - Each mem_readdatavalid writes mem_readdata into line bits [32*recv_cnt+31 : 32*recv_cnt] (word 0 in LSBs), then recv_cnt increments.
  - Issue and receive overlap.
  - Go to FILL the cycle after recv_cnt reaches WORDS.
- FILL, exactly one cycle: fill_we=1, fill_done=1, fill_addr=line_addr, fill_data=assembled line -> IDLE.
- fill_addr and fill_data hold their values after FILL until the next FILL.
- FLUSH:
  - cache_flush=1 for cycles 0..CACHEDEPTH-1 (flush_cnt counter).
  - flush_done=1 when flush_cnt==CACHEDEPTH-1, then -> IDLE.
  - flush_pending clears on entry.
- flush_req while in FETCH or FILL: set flush_pending; serviced from IDLE after the fill completes. flush_req during FLUSH is ignored.
- miss_req while busy: ignored. After FILL, a still-asserted miss_req starts a new refill from IDLE, one idle cycle minimum.
- mem_readdatavalid outside FETCH, or once recv_cnt==WORDS: ignored.
- Reset mid-FETCH: returns to IDLE immediately. Late responses are ignored. No fill_we is issued.
- Latency, zero-wait memory with responses one cycle after acceptance:
  - miss_req sampled in IDLE at cycle 0.
  - Requests accepted in cycles 1..4.
  - Data valid in cycles 2..5.
  - fill_we in cycle 6.
- Counter widths: issue_cnt and recv_cnt are log2(WORDS)+1 bits; flush_cnt is LOG2CACHEDEPTH bits and wraps to 0 at exit.

Test Plan:
1. Reset, then miss_req with miss_addr=0x0000_1234, zero-wait memory returning address-as-data -> mem_address 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles; fill_we in cycle 6; fill_addr=0x1230; fill_data=0x0000123C_00001238_00001234_00001230.
2. mem_waitrequest high for 3 cycles on beat 2, responses delayed 2 cycles -> mem_address held at 0x1238 while stalled; exactly 4 accepted requests; one fill_we with correct line.
3. flush_req pulse in IDLE -> cache_flush high exactly 64 consecutive cycles; flush_done coincident with the 64th; busy low the next cycle.
4. flush_req during FETCH -> fill completes first (fill_we once), then FLUSH starts the cycle after returning to IDLE, 64 cycles.
5. Assert resetn low after 2 beats received -> outputs 0 asynchronously; no fill_we; subsequent readdatavalid pulses ignored; a new miss after reset fetches cleanly.
6. miss_req held high continuously at 0x40 -> back-to-back refills with one IDLE cycle between them; a second miss_req toggle while busy does not restart the burst.
